// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a one-entry
// response register returned to whichever requester won the grant.
//
//   state | meaning
//   EMPTY | response register free; a pending request may be granted
//   FULL  | response register holds a result owned by own_q
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [2:0]       req0_ctrl,
  input  logic [2:0]       req1_ctrl,
  input  logic [WIDTH-1:0] req0_op0,
  input  logic [WIDTH-1:0] req0_op1,
  input  logic [WIDTH-1:0] req1_op0,
  input  logic [WIDTH-1:0] req1_op1,
  output logic [2:0]       alu_control,
  output logic [WIDTH-1:0] alu_operand0,
  output logic [WIDTH-1:0] alu_operand1,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_sign,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  input  logic             rsp0_ready,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [CNTW-1:0]  gnt_cnt0,
  output logic [CNTW-1:0]  gnt_cnt1
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             own_q, own_d;
  logic             pri_q, pri_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]       rsp_flags_q, rsp_flags_d;
  logic [CNTW-1:0]  gnt_cnt0_q, gnt_cnt0_d;
  logic [CNTW-1:0]  gnt_cnt1_q, gnt_cnt1_d;

  logic own_ready;
  logic can_issue;
  logic winner;
  logic grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      own_q        <= 1'b0;
      pri_q        <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      gnt_cnt0_q   <= '0;
      gnt_cnt1_q   <= '0;
    end else begin
      state_q      <= state_d;
      own_q        <= own_d;
      pri_q        <= pri_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      gnt_cnt0_q   <= gnt_cnt0_d;
      gnt_cnt1_q   <= gnt_cnt1_d;
    end
  end

  always_comb begin
    // Only the owner's ready can free the register; the other side is ignored.
    own_ready = own_q ? rsp1_ready : rsp0_ready;
    can_issue = (state_q == EMPTY) || own_ready;
    winner    = (req0_valid && req1_valid) ? pri_q : req1_valid;
    grant     = can_issue && (req0_valid || req1_valid);

    req0_ready   = grant && !winner;
    req1_ready   = grant && winner;
    alu_control  = 3'd0;
    alu_operand0 = '0;
    alu_operand1 = '0;

    state_d      = state_q;
    own_d        = own_q;
    pri_d        = pri_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    gnt_cnt0_d   = gnt_cnt0_q;
    gnt_cnt1_d   = gnt_cnt1_q;

    if (grant) begin
      alu_control  = winner ? req1_ctrl : req0_ctrl;
      alu_operand0 = winner ? req1_op0  : req0_op0;
      alu_operand1 = winner ? req1_op1  : req0_op1;

      state_d      = FULL;
      own_d        = winner;
      pri_d        = !winner;
      rsp_result_d = alu_result;
      rsp_flags_d  = {alu_carry, alu_sign, alu_overflow, alu_zero};
      if (winner) gnt_cnt1_d = gnt_cnt1_q + CNT_ONE;
      else        gnt_cnt0_d = gnt_cnt0_q + CNT_ONE;
    end else if ((state_q == FULL) && own_ready) begin
      state_d = EMPTY;
    end
  end

  assign rsp0_valid = (state_q == FULL) && !own_q;
  assign rsp1_valid = (state_q == FULL) && own_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign gnt_cnt0   = gnt_cnt0_q;
  assign gnt_cnt1   = gnt_cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; a small behavioural ALU (0=ADD, 1=SUB with
// carry meaning borrow) answers whatever the arbiter drives.
module tb_alu_arbiter;
  localparam int WIDTH = 32;
  localparam int CNTW  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0]       req0_ctrl, req1_ctrl, alu_control;
  logic [WIDTH-1:0] req0_op0, req0_op1, req1_op0, req1_op1;
  logic [WIDTH-1:0] alu_operand0, alu_operand1, alu_result;
  logic             alu_carry, alu_sign, alu_overflow, alu_zero;
  logic             rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [3:0]       rsp_flags;
  logic [CNTW-1:0]  gnt_cnt0, gnt_cnt1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_ctrl(req0_ctrl), .req1_ctrl(req1_ctrl),
    .req0_op0(req0_op0), .req0_op1(req0_op1),
    .req1_op0(req1_op0), .req1_op1(req1_op1),
    .alu_control(alu_control), .alu_operand0(alu_operand0), .alu_operand1(alu_operand1),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_sign(alu_sign),
    .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  // Behavioural ALU standing in for the real ArithmeticLogicUnit.
  logic [WIDTH:0] alu_wide;
  always_comb begin
    alu_wide     = '0;
    alu_overflow = 1'b0;
    if (alu_control == 3'd1) begin
      alu_wide     = {1'b0, alu_operand0} - {1'b0, alu_operand1};
      alu_overflow = (alu_operand0[WIDTH-1] != alu_operand1[WIDTH-1]) &&
                     (alu_wide[WIDTH-1] != alu_operand0[WIDTH-1]);
    end else begin
      alu_wide     = {1'b0, alu_operand0} + {1'b0, alu_operand1};
      alu_overflow = (alu_operand0[WIDTH-1] == alu_operand1[WIDTH-1]) &&
                     (alu_wide[WIDTH-1] != alu_operand0[WIDTH-1]);
    end
    alu_result = alu_wide[WIDTH-1:0];
    alu_carry  = alu_wide[WIDTH];
    alu_sign   = alu_wide[WIDTH-1];
    alu_zero   = (alu_wide[WIDTH-1:0] == '0);
  end

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; req0_ctrl = 0; req1_ctrl = 0;
    req0_op0 = 0; req0_op1 = 0; req1_op0 = 0; req1_op1 = 0;
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin n_err++;
      $display("FAIL reset_rsp_valid got %b%b want 00", rsp0_valid, rsp1_valid); end
    n_cmp++; if (rsp_result !== 32'd0 || rsp_flags !== 4'd0) begin n_err++;
      $display("FAIL reset_rsp_data got %h/%b want 0/0", rsp_result, rsp_flags); end
    n_cmp++; if (gnt_cnt0 !== 4'd0 || gnt_cnt1 !== 4'd0) begin n_err++;
      $display("FAIL reset_cnt got %0d/%0d want 0/0", gnt_cnt0, gnt_cnt1); end
    n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || alu_control !== 3'd0 ||
                 alu_operand0 !== 32'd0 || alu_operand1 !== 32'd0) begin n_err++;
      $display("FAIL reset_idle_drive got rdy=%b%b ctrl=%0d op=%h,%h want all 0",
               req0_ready, req1_ready, alu_control, alu_operand0, alu_operand1); end
  endtask

  task automatic test_single_add();
    do_reset();
    req0_valid = 1; req0_ctrl = 3'd0; req0_op0 = 32'd10; req0_op1 = 32'd15; rsp0_ready = 1;
    #1;
    n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_err++;
      $display("FAIL add_ready got %b%b want 10", req0_ready, req1_ready); end
    n_cmp++; if (alu_operand0 !== 32'd10 || alu_operand1 !== 32'd15) begin n_err++;
      $display("FAIL add_alu_drive got %0d,%0d want 10,15", alu_operand0, alu_operand1); end
    next_cycle();
    req0_valid = 0;
    n_cmp++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0) begin n_err++;
      $display("FAIL add_rsp_valid got %b%b want 10", rsp0_valid, rsp1_valid); end
    n_cmp++; if (rsp_result !== 32'd25 || rsp_flags[0] !== 1'b0) begin n_err++;
      $display("FAIL add_result got %0d z=%b want 25 z=0", rsp_result, rsp_flags[0]); end
    n_cmp++; if (gnt_cnt0 !== 4'd1 || gnt_cnt1 !== 4'd0) begin n_err++;
      $display("FAIL add_cnt got %0d/%0d want 1/0", gnt_cnt0, gnt_cnt1); end
    next_cycle();
    n_cmp++; if (rsp0_valid !== 1'b0) begin n_err++;
      $display("FAIL add_drain got rsp0_valid=%b want 0", rsp0_valid); end
  endtask

  task automatic test_contention();
    do_reset();
    req0_valid = 1; req0_ctrl = 3'd0; req0_op0 = 32'd1;   req0_op1 = 32'd1;
    req1_valid = 1; req1_ctrl = 3'd0; req1_op0 = 32'd100; req1_op1 = 32'd1;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (req0_ready !== (k % 2 == 0) || req1_ready !== (k % 2 == 1)) begin n_err++;
        $display("FAIL rr_grant k=%0d got %b%b want winner %0d", k, req0_ready, req1_ready, k % 2); end
      next_cycle();
      n_cmp++; if (rsp0_valid !== (k % 2 == 0) || rsp1_valid !== (k % 2 == 1) ||
                   rsp_result !== ((k % 2 == 0) ? 32'd2 : 32'd101)) begin n_err++;
        $display("FAIL rr_rsp k=%0d got v=%b%b res=%0d", k, rsp0_valid, rsp1_valid, rsp_result); end
    end
    req0_valid = 0; req1_valid = 0;
    n_cmp++; if (gnt_cnt0 !== 4'd2 || gnt_cnt1 !== 4'd2) begin n_err++;
      $display("FAIL rr_cnt got %0d/%0d want 2/2", gnt_cnt0, gnt_cnt1); end
  endtask

  task automatic test_backpressure();
    do_reset();
    req1_valid = 1; req1_ctrl = 3'd1; req1_op0 = 32'd50; req1_op1 = 32'd8;
    #1;
    n_cmp++; if (req1_ready !== 1'b1) begin n_err++;
      $display("FAIL bp_first_grant got %b want 1", req1_ready); end
    next_cycle();
    req1_valid = 0;
    req0_valid = 1; req0_ctrl = 3'd0; req0_op0 = 32'd3; req0_op1 = 32'd4;
    for (int k = 0; k < 3; k++) begin
      rsp0_ready = (k % 2 == 0);
      #1;
      n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || rsp1_valid !== 1'b1 ||
                   rsp_result !== 32'd42) begin n_err++;
        $display("FAIL bp_hold k=%0d got rdy=%b%b v1=%b res=%0d want 00 1 42",
                 k, req0_ready, req1_ready, rsp1_valid, rsp_result); end
      next_cycle();
    end
    rsp0_ready = 0; rsp1_ready = 1;
    #1;
    n_cmp++; if (req0_ready !== 1'b1 || alu_operand0 !== 32'd3) begin n_err++;
      $display("FAIL bp_release got rdy0=%b op0=%0d want 1 3", req0_ready, alu_operand0); end
    next_cycle();
    req0_valid = 0; rsp1_ready = 0;
    n_cmp++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_result !== 32'd7) begin n_err++;
      $display("FAIL bp_refill got v=%b%b res=%0d want 10 7", rsp0_valid, rsp1_valid, rsp_result); end
    n_cmp++; if (gnt_cnt0 !== 4'd1 || gnt_cnt1 !== 4'd1) begin n_err++;
      $display("FAIL bp_cnt got %0d/%0d want 1/1", gnt_cnt0, gnt_cnt1); end
  endtask

  task automatic test_flags_back_to_back();
    logic [2:0]  v_ctrl [4];
    logic [31:0] v_a    [4];
    logic [31:0] v_b    [4];
    logic [31:0] v_res  [4];
    logic [3:0]  v_flg  [4];
    v_ctrl[0] = 3'd1; v_a[0] = 32'd15;         v_b[0] = 32'd15; v_res[0] = 32'd0;         v_flg[0] = 4'b0001;
    v_ctrl[1] = 3'd1; v_a[1] = 32'd0;          v_b[1] = 32'd1;  v_res[1] = 32'hFFFFFFFF;  v_flg[1] = 4'b1100;
    v_ctrl[2] = 3'd0; v_a[2] = 32'h7FFFFFFF;   v_b[2] = 32'd1;  v_res[2] = 32'h80000000;  v_flg[2] = 4'b0110;
    v_ctrl[3] = 3'd0; v_a[3] = 32'hFFFFFFFF;   v_b[3] = 32'd1;  v_res[3] = 32'd0;         v_flg[3] = 4'b1001;
    do_reset();
    rsp0_ready = 1;
    for (int k = 0; k < 4; k++) begin
      req0_valid = 1; req0_ctrl = v_ctrl[k]; req0_op0 = v_a[k]; req0_op1 = v_b[k];
      #1;
      n_cmp++; if (req0_ready !== 1'b1 || alu_control !== v_ctrl[k]) begin n_err++;
        $display("FAIL flags_grant k=%0d got rdy=%b ctrl=%0d", k, req0_ready, alu_control); end
      next_cycle();
      n_cmp++; if (rsp0_valid !== 1'b1 || rsp_result !== v_res[k] || rsp_flags !== v_flg[k]) begin n_err++;
        $display("FAIL flags k=%0d got v=%b res=%h flg=%b want 1 %h %b",
                 k, rsp0_valid, rsp_result, rsp_flags, v_res[k], v_flg[k]); end
    end
    req0_valid = 0;
    n_cmp++; if (gnt_cnt0 !== 4'd4) begin n_err++;
      $display("FAIL flags_cnt got %0d want 4", gnt_cnt0); end
  endtask

  task automatic test_async_reset();
    do_reset();
    req0_valid = 1; req0_ctrl = 3'd0; req0_op0 = 32'd5; req0_op1 = 32'd6;
    next_cycle();
    req0_valid = 0;
    n_cmp++; if (rsp0_valid !== 1'b1 || rsp_result !== 32'd11) begin n_err++;
      $display("FAIL ar_pending got v=%b res=%0d want 1 11", rsp0_valid, rsp_result); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (rsp0_valid !== 1'b0 || rsp_result !== 32'd0 || gnt_cnt0 !== 4'd0) begin n_err++;
      $display("FAIL ar_immediate got v=%b res=%0d cnt=%0d want 0 0 0", rsp0_valid, rsp_result, gnt_cnt0); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1; req1_valid = 1; req1_ctrl = 3'd0; req1_op0 = 32'd9; req1_op1 = 32'd9;
    rsp0_ready = 1; rsp1_ready = 1;
    #1;
    n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_err++;
      $display("FAIL ar_first_tie got %b%b want 10", req0_ready, req1_ready); end
    next_cycle();
    req0_valid = 0; req1_valid = 0;
    n_cmp++; if (rsp0_valid !== 1'b1 || rsp_result !== 32'd11 || gnt_cnt0 !== 4'd1) begin n_err++;
      $display("FAIL ar_after got v=%b res=%0d cnt=%0d want 1 11 1", rsp0_valid, rsp_result, gnt_cnt0); end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    req0_valid = 1; req0_ctrl = 3'd0; req0_op0 = 32'd1; req0_op1 = 32'd2; rsp0_ready = 1;
    repeat (15) next_cycle();
    n_cmp++; if (gnt_cnt0 !== 4'd15) begin n_err++;
      $display("FAIL wrap_15 got %0d want 15", gnt_cnt0); end
    next_cycle();
    n_cmp++; if (gnt_cnt0 !== 4'd0) begin n_err++;
      $display("FAIL wrap_16 got %0d want 0", gnt_cnt0); end
    next_cycle();
    req0_valid = 0;
    n_cmp++; if (gnt_cnt0 !== 4'd1 || gnt_cnt1 !== 4'd0) begin n_err++;
      $display("FAIL wrap_17 got %0d/%0d want 1/0", gnt_cnt0, gnt_cnt1); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single_add();
    test_contention();
    test_backpressure();
    test_flags_back_to_back();
    test_async_reset();
    test_counter_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single ArithmeticLogicUnit instance between two requesters, e.g. the execute stage (port 0) and a multi-cycle sequencer or debug port (port 1). Arbitration is round-robin with valid/ready handshakes. The winning request drives the ALU combinationally. The ALU result and flags are captured into a one-entry response register and returned to the owning requester. The block sits between the requesters and the ALU and is the only driver of the ALU's alu_control/operand0/operand1 inputs.

## Interface
- WIDTH, 32, datapath width; must match the ALU operand width
- CNTW, 16, width of the per-requester grant counters
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  requester i has an operation pending
- req0_ready / req1_ready  out  1  request i accepted this cycle (grant)
- req0_ctrl / req1_ctrl  in  3  ALU control code
- req0_op0, req0_op1 / req1_op0, req1_op1  in  WIDTH  operands
- alu_control  out  3  to ALU alu_control
- alu_operand0, alu_operand1  out  WIDTH  to ALU operand0/operand1
- alu_result  in  WIDTH  from ALU ALUResult
- alu_carry, alu_sign, alu_overflow, alu_zero  in  1  from ALU carryflag/signflag/overflowflag/zflag
- rsp0_valid / rsp1_valid  out  1  response register holds a result owned by requester i
- rsp0_ready / rsp1_ready  in  1  requester i consumes its response
- rsp_result  out  WIDTH  captured result (shared by both requesters)
- rsp_flags  out  4  captured flags {carry, sign, overflow, zero}
- gnt_cnt0, gnt_cnt1  out  CNTW  number of grants issued per requester; wraps modulo 2^CNTW

## Operation
- State: EMPTY (response register free) and FULL (holding a result). Response owner bit `own`. Round-robin pointer `pri` (requester that wins a tie).
- `can_issue` = EMPTY, or FULL with rsp<own>_ready=1 (drain and refill in the same cycle).
- Arbitration when can_issue:
  - Only one valid: that requester wins.
  - Both valid: requester `pri` wins.
  - Neither valid: no grant.
- reqi_ready = can_issue & winner==i. It is combinational from the valids and state. A requester must hold valid and fields stable until ready.
- ALU drive:
  - While a grant is being issued, alu_* outputs carry the winner's ctrl/op0/op1.
  - Otherwise alu_control=0 and operands=0.
- On the grant edge:
  - Capture alu_result and flags into rsp_result/rsp_flags.
  - Set own=winner.
  - Set pri=~winner.
  - Increment gnt_cnt<winner>.
  - Go to FULL.
- In FULL with rsp<own>_ready=1 and no new grant: go to EMPTY. rsp_result/rsp_flags hold their last values.
- rsp_ready from the non-owning requester is ignored.
- rspi_valid = FULL & own==i.
- Control codes are passed through unchecked. The arbiter does not interpret them.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State=EMPTY, own=0, pri=0.
  - rsp0_valid=rsp1_valid=0, rsp_result=0, rsp_flags=0.
  - gnt_cnt0=gnt_cnt1=0.
  - alu_* outputs=0; req*_ready=0 unless a valid is already present after release.
- Reset mid-operation discards the held response and any in-flight grant. There is no replay.
- Latency: request accepted at edge N → rspi_valid=1 for the cycle after edge N, with the result of that request.
- Throughput: one operation per cycle when the owner holds rsp_ready=1 continuously.
- FULL without owner ready: both req*_ready=0, and the response stays stable (no overwrite).
- Fairness: with both valid continuously and immediate drain, grants alternate 0,1,0,1…, starting with 0 after reset.
- Counter wrap: gnt_cnt at 2^CNTW−1 increments to 0. No flag is raised.

## Test plan
- Single add: after reset, req0 ctrl=ADD code, op0=10, op1=15, rsp0_ready=1 → req0_ready=1 that cycle; next cycle rsp0_valid=1, rsp_result=25, zero=0; gnt_cnt0=1.
- Contention: both requesters valid for 4 cycles, rsp ready held 1 → grant order 0,1,0,1; rsp valid alternates owners; gnt_cnt0=gnt_cnt1=2.
- Backpressure: req1 granted, rsp1_ready=0 for 3 cycles while req0 valid → req0_ready=0 throughout, rsp_result stable, rsp0_ready toggling has no effect; rsp1_ready=1 → req0 granted that same cycle.
- Flags: SUB 15−15 → zero=1; SUB 0−1 → sign=1; ADD 0x7FFFFFFF+1 → overflow=1; ADD 0xFFFFFFFF+1 → carry=1, zero=1.
- Async reset while FULL with rsp0 pending → rsp0_valid drops immediately (before the next clk edge); after release, counters=0 and pri=0 (req0 wins the first tie).
- Counter wrap with CNTW=4: 17 grants to req0 → gnt_cnt0=1.
